// File: rtl/fifo_dot_pkg.sv
// fifo_dot_pkg: shared constants, FSM state type and helpers for the
// FIFO-fed dot-product engine.
//   DEF_LANES / DEF_EW  : lanes per 64-bit word and element width
//   DEF_DEPTH           : beats per dot product
//   DEF_ACC_W           : accumulator width (wraps, no saturation)
//   lane_extract()      : signed element i of a packed word
//   sext64()            : sign-extend an accumulator value to 64 bits
package fifo_dot_pkg;

  localparam int DEF_LANES = 8;
  localparam int DEF_EW    = 8;
  localparam int DEF_DEPTH = 8;
  localparam int DEF_ACC_W = 24;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic signed [DEF_EW-1:0] lane_extract(
    input logic [DEF_LANES*DEF_EW-1:0] w,
    input int                          idx
  );
    return w[DEF_EW*idx +: DEF_EW];
  endfunction

  function automatic logic [63:0] sext64(input logic signed [DEF_ACC_W-1:0] v);
    return {{(64-DEF_ACC_W){v[DEF_ACC_W-1]}}, v};
  endfunction

endpackage

// File: rtl/fifo_dot_engine_lane_tree.sv
// dot_lane_tree: lane-wise signed multiply followed by a registered adder
// tree. Fixed 2-cycle latency from (a, b, in_v, in_last) to
// (out_sum, out_v, out_last).
//   clk, rst_n        : clock, async active-low reset (control flags only)
//   a, b              : packed operand words, LANES signed EW-bit elements
//   in_v, in_last     : beat valid / last-beat tag (in_last qualified by in_v)
//   out_sum           : signed sum of the LANES products
//   out_v, out_last   : valid / last tag aligned with out_sum
module dot_lane_tree
  import fifo_dot_pkg::*;
#(
  parameter int  LANES = DEF_LANES,
  parameter int  EW    = DEF_EW,
  localparam int PW    = 2 * EW,
  localparam int SW    = 2 * EW + $clog2(LANES)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LANES*EW-1:0]  a,
  input  logic [LANES*EW-1:0]  b,
  input  logic                 in_v,
  input  logic                 in_last,
  output logic signed [SW-1:0] out_sum,
  output logic                 out_v,
  output logic                 out_last
);

  logic signed [PW-1:0] prod_p1_d [LANES];
  logic signed [PW-1:0] prod_p1_q [LANES];
  logic                 vld_p1_d, vld_p1_q;
  logic                 last_p1_d, last_p1_q;

  logic signed [SW-1:0] sum_p2_d, sum_p2_q;
  logic                 vld_p2_d, vld_p2_q;
  logic                 last_p2_d, last_p2_q;

  always_comb begin
    // ---- stage p1: lane products ----
    vld_p1_d  = in_v;
    last_p1_d = in_v & in_last;
    for (int i = 0; i < LANES; i++) begin
      prod_p1_d[i] = PW'(lane_extract(a, i)) * PW'(lane_extract(b, i));
    end

    // ---- stage p2: adder tree ----
    vld_p2_d  = vld_p1_q;
    last_p2_d = last_p1_q;
    sum_p2_d  = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_p2_d = sum_p2_d + SW'(prod_p1_q[i]);
    end
  end

  always_ff @(posedge clk) begin
    prod_p1_q <= prod_p1_d;
    sum_p2_q  <= sum_p2_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      last_p1_q <= 1'b0;
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      last_p1_q <= last_p1_d;
      vld_p2_q  <= vld_p2_d;
      last_p2_q <= last_p2_d;
    end
  end

  assign out_sum  = sum_p2_q;
  assign out_v    = vld_p2_q;
  assign out_last = last_p2_q;

endmodule

// File: rtl/fifo_dot_engine.sv
// fifo_dot_engine: accumulates the lane-wise signed dot product of DEPTH
// beats of (a_data, b_data) and publishes a sign-extended 64-bit result.
//   clk, rst_n  : clock, async active-low reset
//   start       : begin a new dot product (ignored while busy)
//   in_valid    : a_data/b_data beat valid
//   in_ready    : registered; engine accepts a beat this cycle
//   a_data      : A word, lane i = a_data[EW*i +: EW] signed
//   b_data      : B word, same packing
//   busy        : FSM not idle
//   done        : one-cycle pulse when res updates
//   res         : last completed result, held until the next done
module fifo_dot_engine
  import fifo_dot_pkg::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int EW    = DEF_EW,
  parameter int DEPTH = DEF_DEPTH,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] a_data,
  input  logic [63:0] b_data,
  output logic        busy,
  output logic        done,
  output logic [63:0] res
);

  localparam int SW = 2 * EW + $clog2(LANES);
  localparam int CW = $clog2(DEPTH + 1);

  state_e              state_d, state_q;
  logic [CW-1:0]       cnt_d, cnt_q;
  logic                in_ready_d, in_ready_q;
  logic                accept;

  logic [63:0]         a_p0_d, a_p0_q;
  logic [63:0]         b_p0_d, b_p0_q;
  logic                vld_p0_d, vld_p0_q;
  logic                last_p0_d, last_p0_q;

  logic signed [SW-1:0]    tree_sum;
  logic                    tree_v;
  logic                    tree_last;

  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic signed [ACC_W-1:0] acc_sum;
  logic [63:0]             res_d, res_q;
  logic                    done_d, done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    res_d     = res_q;
    done_d    = 1'b0;
    acc_sum   = acc_q + ACC_W'(tree_sum);
    accept    = in_valid & in_ready_q;

    // ---- stage p0: capture the accepted beat ----
    a_p0_d    = a_data;
    b_p0_d    = b_data;
    vld_p0_d  = accept;
    last_p0_d = accept && (cnt_q == CW'(DEPTH - 1));

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      RUN: begin
        if (accept) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DEPTH - 1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // done_q high means the last beat is sitting in the result stage
        if (done_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // ---- stage p3: accumulate; bubbles leave acc untouched ----
    if (tree_v) begin
      acc_d = acc_sum;
      if (tree_last) begin
        res_d  = sext64(acc_sum);
        done_d = 1'b1;
      end
    end

    // Registered ready: depends only on next state/count, never on in_valid.
    in_ready_d = (state_d == RUN) && (cnt_d < CW'(DEPTH));
  end

  dot_lane_tree #(
    .LANES (LANES),
    .EW    (EW)
  ) u_tree (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a_p0_q),
    .b        (b_p0_q),
    .in_v     (vld_p0_q),
    .in_last  (last_p0_q),
    .out_sum  (tree_sum),
    .out_v    (tree_v),
    .out_last (tree_last)
  );

  always_ff @(posedge clk) begin
    a_p0_q <= a_p0_d;
    b_p0_q <= b_p0_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      vld_p0_q   <= 1'b0;
      last_p0_q  <= 1'b0;
      acc_q      <= '0;
      res_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      vld_p0_q   <= vld_p0_d;
      last_p0_q  <= last_p0_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
      done_q     <= done_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign res      = res_q;

endmodule

// File: tb/tb_fifo_dot_engine.sv
module tb_fifo_dot_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a_data;
  logic [63:0] b_data;
  logic        busy;
  logic        done;
  logic [63:0] res;

  int total = 0;
  int bad   = 0;

  fifo_dot_engine dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_data   (a_data),
    .b_data   (b_data),
    .busy     (busy),
    .done     (done),
    .res      (res)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // One complete dot product. gap = idle cycles between beats, start_beat =
  // beat index during which start is (illegally) re-asserted, -1 for none.
  task automatic run_dot(input string tag, input logic [63:0] a, input logic [63:0] b,
                         input int gap, input int start_beat, input bit vld_at_start,
                         input logic [63:0] prev_res, input logic [63:0] exp_res,
                         input int exp_lat);
    int lat;
    start    = 1'b1;
    in_valid = vld_at_start;
    a_data   = a;
    b_data   = b;
    @(posedge clk); #1;
    start    = 1'b0;
    in_valid = 1'b0;
    check({tag, "_busy_run"}, 64'(busy), 64'd1);
    check({tag, "_ready_run"}, 64'(in_ready), 64'd1);
    check({tag, "_res_hold"}, res, prev_res);
    lat = 0;
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1;
      a_data   = a;
      b_data   = b;
      start    = (k == start_beat);
      @(posedge clk); #1;
      lat++;
      in_valid = 1'b0;
      start    = 1'b0;
      if (k < 7) begin
        repeat (gap) begin
          @(posedge clk); #1;
          lat++;
        end
      end
    end
    check({tag, "_ready_after_last"}, 64'(in_ready), 64'd0);
    if (start_beat >= 0) check({tag, "_res_hold_mid"}, res, prev_res);
    while (!done && lat < 80) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_res"}, res, exp_res);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_res_kept"}, res, exp_res);
  endtask

  initial begin
    bit seen;
    rst_n    = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    a_data   = '0;
    b_data   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_res", res, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_ready", 64'(in_ready), 64'd0);

    // 8 beats of 8 * (1*1); in_valid already high in the start cycle
    run_dot("ones", 64'h0101_0101_0101_0101, 64'h0101_0101_0101_0101,
            0, -1, 1'b1, 64'd0, 64'd64, 11);

    // 64 * (-128 * -128) = 1048576
    run_dot("negneg", 64'h8080_8080_8080_8080, 64'h8080_8080_8080_8080,
            0, -1, 1'b0, 64'd64, 64'h0000_0000_0010_0000, 11);

    // 64 * (-128 * 127) = -1040384
    run_dot("negpos", 64'h8080_8080_8080_8080, 64'h7F7F_7F7F_7F7F_7F7F,
            0, -1, 1'b0, 64'h0000_0000_0010_0000, 64'hFFFF_FFFF_FFF0_2000, 11);

    // lanes a=i+1, b=1, two bubbles between beats: 8*36 = 288, latency 11+14
    run_dot("bubble", 64'h0807_0605_0403_0201, 64'h0101_0101_0101_0101,
            2, -1, 1'b0, 64'hFFFF_FFFF_FFF0_2000, 64'd288, 25);

    // lane b alternates +1/-1: per beat 1-2+3-4+5-6+7-8 = -4, total -32;
    // start re-pulsed during beat 4 must be ignored
    run_dot("restart", 64'h0807_0605_0403_0201, 64'hFF01_FF01_FF01_FF01,
            0, 3, 1'b0, 64'd288, 64'hFFFF_FFFF_FFFF_FFE0, 11);

    // abort with reset while beat 5 is presented
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      a_data   = 64'h0101_0101_0101_0101;
      b_data   = 64'h0101_0101_0101_0101;
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_ready", 64'(in_ready), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_res", res, 64'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    // full run after abort: 64 * (1*2) = 128
    run_dot("post_abort", 64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
            0, -1, 1'b0, 64'd0, 64'd128, 11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
